// File: rtl/pipeline_sequencer_if.sv
// rtl/pipeline_sequencer_if.sv - control/status bundle between the pipeline and its sequencer
interface pipeline_sequencer_if #(
    parameter int COUNTWIDTH = 16
);
    logic                  start;
    logic                  haltD;
    logic                  stallFReq;
    logic                  stallDReq;
    logic                  flushEReq;
    logic                  branchTakenE;
    logic                  memReqM;
    logic                  memAckM;
    logic                  enableF;
    logic                  enableD;
    logic                  enableE;
    logic                  enableM;
    logic                  enableW;
    logic                  flushD;
    logic                  flushE;
    logic                  running;
    logic                  halted;
    logic                  memTimeout;
    logic [COUNTWIDTH-1:0] cycleCount;
    logic [COUNTWIDTH-1:0] stallCount;

    modport master (
        output start, haltD, stallFReq, stallDReq, flushEReq, branchTakenE, memReqM, memAckM,
        input  enableF, enableD, enableE, enableM, enableW, flushD, flushE,
        input  running, halted, memTimeout, cycleCount, stallCount
    );

    modport slave (
        input  start, haltD, stallFReq, stallDReq, flushEReq, branchTakenE, memReqM, memAckM,
        output enableF, enableD, enableE, enableM, enableW, flushD, flushE,
        output running, halted, memTimeout, cycleCount, stallCount
    );
endinterface

// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - run/halt sequencer producing 5-stage pipeline enables, flushes and perf counters
module pipeline_sequencer #(
    parameter int TIMEOUT    = 8,
    parameter int COUNTWIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    pipeline_sequencer_if.slave  bus
);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_MEMWAIT, S_DRAIN, S_HALTED, S_ERROR
    } state_t;

    state_t                state_q, state_d;
    logic [WW-1:0]         wait_q, wait_d;
    logic [1:0]            drain_q, drain_d;
    logic [COUNTWIDTH-1:0] cycle_cnt_q, stall_cnt_q;

    logic en_f, en_d, en_emw, fl_d, fl_e;
    logic freeze, timed_out;
    logic run_en_f, run_en_d, run_fl_d, run_fl_e, run_halt;

    assign freeze    = bus.memReqM & ~bus.memAckM;
    assign timed_out = (wait_q == WW'(TIMEOUT));

    // Normal RUN behaviour: a taken branch wins over stall requests and halt entry.
    assign run_en_f = bus.branchTakenE | ~bus.stallFReq;
    assign run_en_d = bus.branchTakenE | ~bus.stallDReq;
    assign run_fl_d = bus.branchTakenE;
    assign run_fl_e = bus.branchTakenE | bus.flushEReq;
    assign run_halt = ~bus.branchTakenE & bus.haltD & ~bus.stallDReq;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        drain_d = drain_q;
        en_f    = 1'b0;
        en_d    = 1'b0;
        en_emw  = 1'b0;
        fl_d    = 1'b0;
        fl_e    = 1'b0;
        case (state_q)
            S_IDLE: begin
                fl_d = 1'b1;
                fl_e = 1'b1;
                if (bus.start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN, S_MEMWAIT: begin
                if ((state_q == S_RUN) ? freeze : ~bus.memAckM) begin
                    if (state_q == S_RUN) begin
                        state_d = S_MEMWAIT;
                        wait_d  = WW'(1);
                    end else if (timed_out) begin
                        state_d = S_ERROR;
                    end else begin
                        wait_d = wait_q + WW'(1);
                    end
                end else begin
                    en_f    = run_en_f;
                    en_d    = run_en_d;
                    en_emw  = 1'b1;
                    fl_d    = run_fl_d;
                    fl_e    = run_fl_e;
                    wait_d  = '0;
                    state_d = run_halt ? S_DRAIN : S_RUN;
                    if (run_halt) begin
                        drain_d = '0;
                    end
                end
            end
            S_DRAIN: begin
                fl_d = 1'b1;
                // Wait counter starts at 0 here so the total freeze budget matches RUN+MEMWAIT.
                if (freeze) begin
                    if (timed_out) begin
                        state_d = S_ERROR;
                    end else begin
                        wait_d = wait_q + WW'(1);
                    end
                end else begin
                    en_emw = 1'b1;
                    wait_d = '0;
                    if (drain_q == 2'd2) begin
                        state_d = S_HALTED;
                    end else begin
                        drain_d = drain_q + 2'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wait_q      <= '0;
            drain_q     <= '0;
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            drain_q <= drain_d;
            if ((state_q == S_RUN || state_q == S_MEMWAIT || state_q == S_DRAIN)
                && cycle_cnt_q != '1) begin
                cycle_cnt_q <= cycle_cnt_q + 1'b1;
            end
            if ((state_q == S_RUN || state_q == S_MEMWAIT) && !en_f && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign bus.enableF    = en_f;
    assign bus.enableD    = en_d;
    assign bus.enableE    = en_emw;
    assign bus.enableM    = en_emw;
    assign bus.enableW    = en_emw;
    assign bus.flushD     = fl_d;
    assign bus.flushE     = fl_e;
    assign bus.running    = (state_q == S_RUN) || (state_q == S_MEMWAIT) || (state_q == S_DRAIN);
    assign bus.halted     = (state_q == S_HALTED);
    assign bus.memTimeout = (state_q == S_ERROR);
    assign bus.cycleCount = cycle_cnt_q;
    assign bus.stallCount = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb/tb_pipeline_sequencer.sv - directed bench with a per-cycle reference model of the sequencer
module tb_pipeline_sequencer;
    localparam int TO   = 8;
    localparam int CMAX = 65535;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pipeline_sequencer_if #(.COUNTWIDTH(16)) sif ();
    pipeline_sequencer_if #(.COUNTWIDTH(4))  sif4 ();

    pipeline_sequencer #(.TIMEOUT(TO), .COUNTWIDTH(16)) dut  (.clk(clk), .reset(reset), .bus(sif));
    pipeline_sequencer #(.TIMEOUT(TO), .COUNTWIDTH(4))  dut4 (.clk(clk), .reset(reset), .bus(sif4));

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit checking  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: mode 0 idle, 1 active, 2 halted, 3 error; frozen = consecutive unacked freeze cycles.
    int m_mode = 0, m_frozen = 0, m_drain_left = 0, m_cyc = 0, m_stall = 0;
    int n_mode, n_frozen, n_drain_left, n_cyc, n_stall;

    always @(negedge clk) begin
        if (checking) begin
            bit eF, eD, eE, fD, fE, fz, halt_req;
            eF = 0; eD = 0; eE = 0; fD = 0; fE = 0;
            n_mode = m_mode; n_frozen = m_frozen; n_drain_left = m_drain_left;
            n_cyc = m_cyc; n_stall = m_stall;
            if (m_mode == 0) begin
                fD = 1; fE = 1;
                if (sif.start) n_mode = 1;
            end else if (m_mode == 1) begin
                if (n_cyc < CMAX) n_cyc++;
                if (m_drain_left > 0) begin
                    fD = 1;
                    fz = sif.memReqM && !sif.memAckM;
                    if (fz) begin
                        if (m_frozen + 1 > TO) n_mode = 3; else n_frozen = m_frozen + 1;
                    end else begin
                        eE = 1; n_frozen = 0;
                        n_drain_left = m_drain_left - 1;
                        if (n_drain_left == 0) n_mode = 2;
                    end
                end else begin
                    fz = (m_frozen > 0) ? !sif.memAckM : (sif.memReqM && !sif.memAckM);
                    if (fz) begin
                        if (m_frozen + 1 > TO) n_mode = 3; else n_frozen = m_frozen + 1;
                    end else begin
                        n_frozen = 0; eE = 1;
                        if (sif.branchTakenE) begin
                            eF = 1; eD = 1; fD = 1; fE = 1; halt_req = 0;
                        end else begin
                            eF = !sif.stallFReq; eD = !sif.stallDReq; fE = sif.flushEReq;
                            halt_req = sif.haltD && !sif.stallDReq;
                        end
                        if (halt_req) n_drain_left = 3;
                    end
                    if (!eF && n_stall < CMAX) n_stall++;
                end
            end
            check("outputs",
                  {sif.enableF, sif.enableD, sif.enableE, sif.enableM, sif.enableW,
                   sif.flushD, sif.flushE, sif.running, sif.halted, sif.memTimeout},
                  {eF, eD, eE, eE, eE, fD, fE, m_mode == 1, m_mode == 2, m_mode == 3});
            check("cycleCount", sif.cycleCount, m_cyc);
            check("stallCount", sif.stallCount, m_stall);
            if (reset) begin
                n_mode = 0; n_frozen = 0; n_drain_left = 0; n_cyc = 0; n_stall = 0;
            end
        end
    end

    always @(posedge clk) begin
        if (checking) begin
            m_mode <= n_mode; m_frozen <= n_frozen; m_drain_left <= n_drain_left;
            m_cyc <= n_cyc; m_stall <= n_stall;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        {sif.start, sif.haltD, sif.stallFReq, sif.stallDReq} = '0;
        {sif.flushEReq, sif.branchTakenE, sif.memReqM, sif.memAckM} = '0;
        {sif4.start, sif4.haltD, sif4.stallFReq, sif4.stallDReq} = '0;
        {sif4.flushEReq, sif4.branchTakenE, sif4.memReqM, sif4.memAckM} = '0;
        tick(2);
        checking = 1'b1;
        check("reset cycleCount", sif.cycleCount, 0);
        check("reset running", sif.running, 0);
        reset = 1'b0;
        sif.start = 1; tick(); sif.start = 0;
        check("run entered", sif.running, 1);
        tick(10);
        check("10 cycles cycleCount", sif.cycleCount, 10);
        check("10 cycles stallCount", sif.stallCount, 0);

        // hazard stall, then the same request overridden by a taken branch
        sif.stallFReq = 1; sif.stallDReq = 1; sif.flushEReq = 1; #1;
        check("stall enableF", sif.enableF, 0);
        check("stall flushE", sif.flushE, 1);
        tick();
        check("stall stallCount", sif.stallCount, 1);
        sif.branchTakenE = 1; #1;
        check("branch enableF", sif.enableF, 1);
        check("branch flushD", sif.flushD, 1);
        tick();
        check("branch stallCount", sif.stallCount, 1);
        {sif.stallFReq, sif.stallDReq, sif.flushEReq, sif.branchTakenE} = '0;

        // memory wait acknowledged after four frozen cycles
        sif.memReqM = 1; tick(4);
        sif.memAckM = 1; #1;
        check("ack enableF", sif.enableF, 1);
        tick();
        sif.memReqM = 0; sif.memAckM = 0;
        check("memwait cycleCount", sif.cycleCount, 17);
        check("memwait stallCount", sif.stallCount, 5);
        tick();

        // halt with branch is ignored, plain halt drains with a freeze inside
        sif.haltD = 1; sif.branchTakenE = 1; tick();
        sif.haltD = 0; sif.branchTakenE = 0; #1;
        check("halt+branch no drain", sif.enableF, 1);
        sif.haltD = 1; tick(); sif.haltD = 0; #1;
        check("drain enableF", sif.enableF, 0);
        check("drain enableE", sif.enableE, 1);
        tick();
        sif.memReqM = 1; #1;
        check("drain freeze enableE", sif.enableE, 0);
        tick(2);
        sif.memReqM = 0; tick(2);
        check("halted", sif.halted, 1);
        check("halt cycleCount", sif.cycleCount, 25);
        sif.start = 1; tick(); sif.start = 0;
        check("halted sticky", sif.halted, 1);

        // timeout into ERROR
        reset = 1; tick(); reset = 0;
        check("reset from halted cycleCount", sif.cycleCount, 0);
        sif.start = 1; tick(); sif.start = 0;
        sif.memReqM = 1; tick(8);
        check("no timeout yet", sif.memTimeout, 0);
        tick();
        check("timeout", sif.memTimeout, 1);
        check("timeout stallCount", sif.stallCount, 9);
        sif.start = 1; tick(); sif.start = 0;
        check("error sticky", sif.memTimeout, 1);
        check("error cycleCount", sif.cycleCount, 9);
        reset = 1; tick(); reset = 0; sif.memReqM = 0;
        check("reset from error", sif.memTimeout, 0);

        // ack on the TIMEOUT-th wait cycle is still accepted
        sif.start = 1; tick(); sif.start = 0;
        sif.memReqM = 1; tick(8);
        sif.memAckM = 1; tick();
        sif.memReqM = 0; sif.memAckM = 0;
        check("late ack running", sif.running, 1);
        check("late ack memTimeout", sif.memTimeout, 0);
        check("late ack stallCount", sif.stallCount, 8);
        tick();

        // 4-bit counters saturate
        sif4.start = 1; tick(); sif4.start = 0;
        tick(15);
        check("cw4 at 15", sif4.cycleCount, 15);
        tick(5);
        check("cw4 saturated", sif4.cycleCount, 15);
        check("cw4 stallCount", sif4.stallCount, 0);

        checking = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
